uart_rx_fifo: RTL

- Parametrised successor to the WimpFi UART byte receiver; feeds the transmit-side frame path (dest, src, type, data…, 0x04 EOT).
- Adds configurable data width, parity, stop bits and oversampling.
- Adds start-bit glitch rejection, break detection, and a show-ahead receive FIFO with valid/ready output.
- Sticky error flags report framing and overrun errors; parity errors are flagged per byte.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
//   parity_t   : parity mode selector
//   rx_state_t : receive FSM states
//   calc_div   : clocks per oversample tick, rounded to nearest, minimum 1
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK_WAIT} rx_state_t;

    function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
        longint d;
        d = (clk_freq + (baud * os) / 2) / (baud * os);
        return (d < 1) ? 1 : int'(d);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
//   push/wdata : write request; dropped when full unless a pop happens in the same cycle
//   pop        : removes the head entry; ignored when empty (no write-through bypass)
//   rdata      : head entry, valid whenever !empty
//   count      : exact occupancy 0..DEPTH; full/empty decoded from it
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the simultaneous push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with start-glitch rejection, break detection
// and a show-ahead receive FIFO.
//   rxd            : async serial line (idle high)
//   ready          : consumer pops the head entry when valid
//   clr_err        : pulse clearing the sticky ferr/oerr flags
//   data/perr      : head character and its parity-error flag
//   valid/count    : FIFO non-empty / occupancy
//   ferr/oerr      : sticky framing / overrun errors
//   brk            : break condition held on the line
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int      CLK_FREQ   = 100_000_000,
    parameter int      BAUD_RATE  = 9600,
    parameter int      OVERSAMPLE = 16,
    parameter int      DATA_BITS  = 8,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    input  logic                          ready,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          data,
    output logic                          perr,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          ferr,
    output logic                          oerr,
    output logic                          brk
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TLAST = TW'(DIV - 1);
    localparam logic [SW-1:0] HALF  = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic          SLAST = 1'(STOP_BITS - 1);

    logic [1:0]           rxd_q;
    logic                 rxd_s;
    logic [TW-1:0]        tcnt;
    logic                 tick;
    rx_state_t            state, state_n;
    logic [SW-1:0]        scnt, scnt_n;
    logic [BW-1:0]        bidx, bidx_n;
    logic                 sidx, sidx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 pbad, pbad_n;
    logic                 sbad, sbad_n, stop_bad;
    logic                 push_n, push_q, ferr_set, oerr_set;
    logic [DATA_BITS:0]   pdata_q, fifo_rdata;
    logic                 fifo_full, fifo_empty;

    assign rxd_s = rxd_q[1];
    assign tick  = (tcnt == TLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q <= 2'b11;
            tcnt  <= '0;
        end else begin
            rxd_q <= {rxd_q[0], rxd};
            tcnt  <= tick ? '0 : tcnt + 1'b1;
        end
    end

    // Stop-bit verdict includes the sample taken this tick.
    assign stop_bad = sbad | ~rxd_s;

    always_comb begin
        state_n  = state;
        scnt_n   = scnt;
        bidx_n   = bidx;
        sidx_n   = sidx;
        shreg_n  = shreg;
        pbad_n   = pbad;
        sbad_n   = sbad;
        push_n   = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: if (!rxd_s) begin
                state_n = START;
                scnt_n  = '0;
            end
            START: if (tick) begin
                if (scnt == HALF) begin
                    scnt_n = '0;
                    if (rxd_s) state_n = IDLE;  // too short to be a start bit
                    else begin
                        state_n = DATA;
                        bidx_n  = '0;
                        sidx_n  = 1'b0;
                        pbad_n  = 1'b0;
                        sbad_n  = 1'b0;
                    end
                end else scnt_n = scnt + 1'b1;
            end
            DATA: if (tick) begin
                if (scnt == LAST) begin
                    scnt_n  = '0;
                    shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
                    bidx_n  = bidx + 1'b1;
                    if (bidx == BLAST) state_n = (PARITY == PAR_NONE) ? STOP : PAR;
                end else scnt_n = scnt + 1'b1;
            end
            PAR: if (tick) begin
                if (scnt == LAST) begin
                    scnt_n  = '0;
                    pbad_n  = (^shreg) ^ rxd_s ^ (PARITY == PAR_ODD);
                    state_n = STOP;
                end else scnt_n = scnt + 1'b1;
            end
            STOP: if (tick) begin
                if (scnt == LAST) begin
                    scnt_n = '0;
                    if (sidx == SLAST) begin
                        if (!stop_bad) begin
                            push_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_n  = (shreg == '0 && !rxd_s) ? BRK_WAIT : IDLE;
                        end
                    end else begin
                        sidx_n = 1'b1;
                        sbad_n = stop_bad;
                    end
                end else scnt_n = scnt + 1'b1;
            end
            BRK_WAIT: begin
                // Line must stay high for a whole bit time before we re-arm.
                if (!rxd_s) scnt_n = '0;
                else if (tick) begin
                    if (scnt == LAST) state_n = IDLE;
                    else scnt_n = scnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            scnt    <= '0;
            bidx    <= '0;
            sidx    <= 1'b0;
            shreg   <= '0;
            pbad    <= 1'b0;
            sbad    <= 1'b0;
            push_q  <= 1'b0;
            pdata_q <= '0;
        end else begin
            state  <= state_n;
            scnt   <= scnt_n;
            bidx   <= bidx_n;
            sidx   <= sidx_n;
            shreg  <= shreg_n;
            pbad   <= pbad_n;
            sbad   <= sbad_n;
            push_q <= push_n;
            if (push_n) pdata_q <= {pbad, shreg};
        end
    end

    assign oerr_set = push_q && fifo_full && !ready;

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr <= 1'b0;
            oerr <= 1'b0;
        end else begin
            ferr <= ferr_set | (ferr & ~clr_err);
            oerr <= oerr_set | (oerr & ~clr_err);
        end
    end

    sync_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (pdata_q),
        .pop   (ready),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign data  = fifo_rdata[DATA_BITS-1:0];
    assign perr  = fifo_rdata[DATA_BITS];
    assign valid = !fifo_empty;
    assign brk   = (state == BRK_WAIT);
endmodule
